// File: rtl/mul_seq_unit.sv
// mul_seq_unit: sequential 32x32 RV32M multiplier (MUL, MULH, MULHSU, MULHU).
// Shift-and-add over operand magnitudes through a 64-bit ripple-carry add
// path (two chained 32-bit stages), followed by a conditional two's-complement
// fix-up. A start/busy/done handshake connects it to the multicycle control.
//
// Optional feature macro: MUL_EARLY_EXIT_EN
//   defined   -> CALC ends as soon as the remaining multiplier bits are zero
//                (always at least one iteration), giving operand-dependent latency.
//   undefined -> fixed 32 iterations, 35-cycle latency.
module mul_seq_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  logic [2:0]  state_q,   state_d;
  logic [1:0]  op_q,      op_d;
  logic [31:0] a_q,       a_d;
  logic [31:0] b_q,       b_d;
  logic        neg_q,     neg_d;
  logic [63:0] mcand_q,   mcand_d;
  logic [31:0] mplier_q,  mplier_d;
  logic [4:0]  count_q,   count_d;
  logic [63:0] product_q, product_d;
  logic [31:0] result_q,  result_d;

  logic [63:0] addA;
  logic [63:0] addB;
  logic        addCin;
  logic [63:0] addSum;

  logic        aSigned;
  logic        bSigned;
  logic        aNeg;
  logic        bNeg;
  logic [31:0] absA;
  logic [31:0] absB;

  // Bit-level ripple chain across 64 bits. The carry leaving bit 31 is the low
  // stage's Cout feeding the high stage's Cin; the carry out of bit 63 is
  // dropped, which keeps the product exact modulo 2^64.
  function automatic logic [63:0] addPath64(input logic [63:0] x,
                                            input logic [63:0] y,
                                            input logic        cin);
    logic [63:0] s;
    logic        c;
    c = cin;
    for (int i = 0; i < 64; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return s;
  endfunction

  // Adder operand select: accumulate the shifted multiplicand in CALC,
  // compute ~product + 1 in FIX.
  always_comb begin
    addA   = product_q;
    addB   = mcand_q;
    addCin = 1'b0;
    if (state_q == S_FIX) begin
      addA   = ~product_q;
      addB   = 64'd0;
      addCin = 1'b1;
    end
    addSum = addPath64(addA, addB, addCin);
  end

  // Operand sign handling: rs1 is signed for MULH/MULHSU, rs2 only for MULH.
  always_comb begin
    aSigned = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    bSigned = (op_q == OP_MULH);
    aNeg    = aSigned & a_q[31];
    bNeg    = bSigned & b_q[31];
    absA    = aNeg ? (~a_q + 32'd1) : a_q;
    absB    = bNeg ? (~b_q + 32'd1) : b_q;
  end

  // Next-state and datapath update for the IDLE/PREP/CALC/FIX/DONE sequence.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_d     = neg_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          a_d       = a;
          b_d       = b;
          product_d = 64'd0;
          state_d   = S_PREP;
        end
      end

      S_PREP: begin
        neg_d    = aNeg ^ bNeg;
        mcand_d  = {32'd0, absA};
        mplier_d = absB;
        count_d  = 5'd0;
        state_d  = S_CALC;
      end

      S_CALC: begin
        if (mplier_q[0]) begin
          product_d = addSum;
        end
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        count_d  = count_q + 5'd1;
`ifdef MUL_EARLY_EXIT_EN
        if ((count_q == 5'd31) || (mplier_q[31:1] == 31'd0)) begin
          state_d = S_FIX;
        end
`else
        if (count_q == 5'd31) begin
          state_d = S_FIX;
        end
`endif
      end

      S_FIX: begin
        if (neg_q) begin
          product_d = addSum;
        end
        result_d = (op_q == OP_MUL) ? product_d[31:0] : product_d[63:32];
        state_d  = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      neg_q     <= 1'b0;
      mcand_q   <= 64'd0;
      mplier_q  <= 32'd0;
      count_q   <= 5'd0;
      product_q <= 64'd0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// tb_mul_seq_unit: self-checking bench for mul_seq_unit. A behavioural model
// (64-bit arithmetic product plus a latency countdown) predicts busy, done and
// result every cycle; directed cases pin known products and latencies.
module tb_mul_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int passCount  = 0;
  int checkCount = 0;

  int          modelLeft    = 0;
  bit          modelValid   = 1'b0;
  logic [31:0] modelPending = 32'd0;
  logic [31:0] modelResult  = 32'd0;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mul_seq_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Architectural product: extend each operand per its signedness, multiply
  // modulo 2^64, select the requested word.
  function automatic logic [31:0] refResult(input logic [1:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
    logic [63:0] xe;
    logic [63:0] ye;
    logic [63:0] p;
    xe = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'h0, x};
    ye = (o == 2'b01) ? {{32{y[31]}}, y} : {32'h0, y};
    p  = xe * ye;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Cycles from the accepting edge to the done cycle.
  function automatic int refLatency(input logic [1:0] o, input logic [31:0] y);
    logic [31:0] mag;
    int          len;
    mag = (o == 2'b01 && y[31]) ? (32'd0 - y) : y;
    len = 0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) len = i + 1;
    end
    return EARLY ? (3 + ((len < 1) ? 1 : len)) : 35;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update on each rising edge from the inputs driven at the previous falling edge.
  always @(posedge clk) begin
    if (rst) begin
      modelLeft   = 0;
      modelResult = 32'd0;
      modelValid  = 1'b1;
    end else if (modelValid) begin
      if (modelLeft == 0) begin
        if (start) begin
          modelPending = refResult(op, a, b);
          modelLeft    = refLatency(op, b);
        end
      end else begin
        modelLeft--;
        if (modelLeft == 1) modelResult = modelPending;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("busy",   {31'd0, busy},   {31'd0, (modelLeft > 0)});
      checkOutput("done",   {31'd0, done},   {31'd0, (modelLeft == 1)});
      checkOutput("result", result, modelResult);
    end
  end

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x,
                               input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic waitDone(input int startN, output int endN);
    int n;
    n = startN;
    while (done !== 1'b1 && n < startN + 200) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checkCount++;
      $display("[TB] FAIL done_timeout: no done within 200 cycles at %0t", $time);
    end
    endN = n;
  endtask

  task automatic runOp(input string name, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] expRes);
    int n;
    applyStimulus(o, x, y);
    waitDone(1, n);
    checkOutput({name, "_result"}, result, expRes);
    checkOutput({name, "_latency"}, 32'(n), 32'(refLatency(o, y)));
  endtask

  initial begin
    int n;
    int l1;
    int doneSeen;
    rst   = 1'b1;
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd7;
    b     = 32'd6;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy",   {31'd0, busy}, 32'd0);
    checkOutput("reset_done",   {31'd0, done}, 32'd0);
    checkOutput("reset_result", result,        32'd0);
    rst   = 1'b0;
    start = 1'b0;

    runOp("mul_7x6",       2'b00, 32'd7,          32'd6,          32'h0000002A);
    runOp("mulh_min",      2'b01, 32'h80000000,   32'h80000000,   32'h40000000);
    runOp("mul_min",       2'b00, 32'h80000000,   32'h80000000,   32'h00000000);
    runOp("mulhu_ones",    2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE);
    runOp("mulhsu_ones",   2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF);
    runOp("mulh_ones",     2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000);
    runOp("mul_5x3",       2'b00, 32'd5,          32'd3,          32'd15);
    runOp("mul_9x0",       2'b00, 32'd9,          32'd0,          32'd0);
    runOp("mulh_neg",      2'b01, 32'hFFFFFFFD,   32'd7,          32'hFFFFFFFF);

    // Back-to-back with start held high throughout.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd7;
    b     = 32'd6;
    @(negedge clk);
    a = 32'd3;
    b = 32'd5;
    waitDone(1, n);
    l1 = n;
    checkOutput("b2b_first_result",  result, 32'h0000002A);
    checkOutput("b2b_first_latency", 32'(l1), 32'(refLatency(2'b00, 32'd6)));
    @(negedge clk);
    waitDone(n + 1, n);
    start = 1'b0;
    checkOutput("b2b_second_result", result, 32'h0000000F);
    checkOutput("b2b_second_cycle",  32'(n), 32'(l1 + 1 + refLatency(2'b00, 32'd5)));

    // Reset in cycle 10 of an operation.
    applyStimulus(2'b00, 32'd1234, 32'd5678);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy",   {31'd0, busy}, 32'd0);
    checkOutput("abort_done",   {31'd0, done}, 32'd0);
    checkOutput("abort_result", result,        32'd0);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
    runOp("mul_2x2", 2'b00, 32'd2, 32'd2, 32'd4);

    // Randomized traffic: random starts (also while busy), operands and rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        logic [31:0] v;
        case ($urandom_range(0, 5))
          0:       v = 32'd0;
          1:       v = 32'h80000000;
          2:       v = 32'hFFFFFFFF;
          3:       v = $urandom_range(0, 15);
          default: v = $urandom;
        endcase
        if (k == 0) a = v;
        else        b = v;
      end
      rst = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
